// File: rtl/ecc_ram_pkg.sv
// ecc_ram_pkg
//   Shared definitions for the ECC multiplier RAM sequencers:
//   command codes, the chunk-swap FSM state encoding and the
//   RAM select encodings used on the source/destination select inputs.
package ecc_ram_pkg;

    localparam logic [3:0] CMD_SWAP = 4'h5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } swap_state_t;

    // Source select: 1 = RAM C, 0 = RAM D.
    localparam logic SRC_C = 1'b1;
    localparam logic SRC_D = 1'b0;
    // Destination select: 1 = RAM A, 0 = RAM B.
    localparam logic DST_A = 1'b1;
    localparam logic DST_B = 1'b0;

endpackage

// File: rtl/ram_rd_lat_pipe.sv
// ram_rd_lat_pipe
//   Delay line that models RAM read latency for a sequencer: a token
//   (valid + index) presented on the input appears on the output exactly
//   DEPTH cycles later. Cleared by the synchronous reset.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_idx    token entering the line this cycle
//   out_valid, out_idx  token leaving the line this cycle
//   busy                any token still in flight
module ram_rd_lat_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy
);

    logic [DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];
    assign busy      = |vld;

endmodule

// File: rtl/ram_chunk_swap_sequencer.sv
// ram_chunk_swap_sequencer
//   On CMD_SWAP, streams n = min(num_chunks, CHUNK_MAX) chunks from RAM C/D
//   into RAM A/B, addresses walking downward from read_addr / write_addr.
//   Source addresses are issued one per cycle; each issue's destination
//   write appears RD_LAT cycles later. A one-cycle interrupt marks completion.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   command                           command bus (CMD_SWAP starts a transfer)
//   read_addr, write_addr, num_chunks transfer parameters, sampled at start
//   select_ram_c_or_d                 1 = source C, 0 = source D
//   select_ram_a_or_b                 1 = destination A, 0 = destination B
//   adbus_c, adbus_d                  source read addresses
//   select_ram_c_dma/_d_dma           read-data steering to the destination
//   w_a/adbus_a, w_b/adbus_b          destination write enables and addresses
//   cmd_swap                          busy flag
//   cmd_reject                        CMD_SWAP seen while busy (combinational)
//   interrupt                         one-cycle completion pulse
module ram_chunk_swap_sequencer #(
    parameter int         ADDR_W    = 3,
    parameter int         CHUNK_MAX = 4,
    parameter int         RD_LAT    = 2,
    parameter logic [3:0] CMD_SWAP  = ecc_ram_pkg::CMD_SWAP
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       command,
    input  logic [ADDR_W-1:0]                read_addr,
    input  logic [ADDR_W-1:0]                write_addr,
    input  logic [$clog2(CHUNK_MAX+1)-1:0]   num_chunks,
    input  logic                             select_ram_c_or_d,
    input  logic                             select_ram_a_or_b,
    output logic [ADDR_W-1:0]                adbus_c,
    output logic [ADDR_W-1:0]                adbus_d,
    output logic                             select_ram_c_dma,
    output logic                             select_ram_d_dma,
    output logic                             w_a,
    output logic [ADDR_W-1:0]                adbus_a,
    output logic                             w_b,
    output logic [ADDR_W-1:0]                adbus_b,
    output logic                             cmd_swap,
    output logic                             cmd_reject,
    output logic                             interrupt
);
    import ecc_ram_pkg::*;

    localparam int CNT_W = $clog2(CHUNK_MAX+1);

    swap_state_t       state;
    logic [ADDR_W-1:0] rd_base, wr_base;
    logic [CNT_W-1:0]  n_lat, next_k;
    logic              src_sel, dst_sel;

    logic              start;
    logic [CNT_W-1:0]  n_clamped;
    logic              launch_valid;
    logic [CNT_W-1:0]  launch_idx;
    logic              tok_valid;
    logic [CNT_W-1:0]  tok_idx;
    logic              pipe_busy;

    // The token for issue k enters the delay line in the cycle before its
    // address becomes visible, so it leaves the line one cycle before the
    // write and the write outputs can be registered: address at T+1+k,
    // write at T+1+RD_LAT+k.
    always_comb begin
        start        = (state == IDLE) && (command == CMD_SWAP);
        n_clamped    = (num_chunks > CNT_W'(CHUNK_MAX)) ? CNT_W'(CHUNK_MAX) : num_chunks;
        launch_valid = (start && (n_clamped != '0)) ||
                       ((state == ISSUE) && (next_k < n_lat));
        launch_idx   = (state == IDLE) ? '0 : next_k;
    end

    assign cmd_reject = !rst && cmd_swap && (command == CMD_SWAP);

    ram_rd_lat_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (CNT_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (launch_valid),
        .in_idx    (launch_idx),
        .out_valid (tok_valid),
        .out_idx   (tok_idx),
        .busy      (pipe_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_base          <= '0;
            wr_base          <= '0;
            n_lat            <= '0;
            next_k           <= '0;
            src_sel          <= 1'b0;
            dst_sel          <= 1'b0;
            adbus_c          <= '0;
            adbus_d          <= '0;
            select_ram_c_dma <= 1'b0;
            select_ram_d_dma <= 1'b0;
            w_a              <= 1'b0;
            adbus_a          <= '0;
            w_b              <= 1'b0;
            adbus_b          <= '0;
            cmd_swap         <= 1'b0;
            interrupt        <= 1'b0;
        end else begin
            // Write path: driven purely by tokens leaving the delay line.
            w_a              <= 1'b0;
            w_b              <= 1'b0;
            select_ram_c_dma <= 1'b0;
            select_ram_d_dma <= 1'b0;
            if (tok_valid) begin
                select_ram_c_dma <= (src_sel == SRC_C);
                select_ram_d_dma <= (src_sel != SRC_C);
                if (dst_sel == DST_A) begin
                    w_a     <= 1'b1;
                    adbus_a <= wr_base - ADDR_W'(tok_idx);
                end else begin
                    w_b     <= 1'b1;
                    adbus_b <= wr_base - ADDR_W'(tok_idx);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rd_base  <= read_addr;
                        wr_base  <= write_addr;
                        n_lat    <= n_clamped;
                        src_sel  <= select_ram_c_or_d;
                        dst_sel  <= select_ram_a_or_b;
                        cmd_swap <= 1'b1;
                        if (n_clamped == '0) begin
                            state     <= DONE;
                            interrupt <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            next_k <= CNT_W'(1);
                            if (select_ram_c_or_d == SRC_C) adbus_c <= read_addr;
                            else                            adbus_d <= read_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (next_k < n_lat) begin
                        next_k <= next_k + CNT_W'(1);
                        if (src_sel == SRC_C) adbus_c <= rd_base - ADDR_W'(next_k);
                        else                  adbus_d <= rd_base - ADDR_W'(next_k);
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state     <= DONE;
                        interrupt <= 1'b1;
                    end
                end
                DONE: begin
                    interrupt <= 1'b0;
                    cmd_swap  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_chunk_swap_sequencer.sv
// tb_ram_chunk_swap_sequencer
//   Directed cycle-by-cycle bench. Every cycle of each transfer compares the
//   complete output bundle against a hand-computed vector.
//   Bundle order: adbus_c, adbus_d, c_dma, d_dma, w_a, adbus_a, w_b, adbus_b,
//   cmd_swap, cmd_reject, interrupt.
module tb_ram_chunk_swap_sequencer;

    localparam int ADDR_W    = 3;
    localparam int CHUNK_MAX = 4;
    localparam int RD_LAT    = 2;
    localparam int CNT_W     = $clog2(CHUNK_MAX+1);

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        command;
    logic [ADDR_W-1:0] read_addr, write_addr;
    logic [CNT_W-1:0]  num_chunks;
    logic              select_ram_c_or_d, select_ram_a_or_b;
    logic [ADDR_W-1:0] adbus_c, adbus_d, adbus_a, adbus_b;
    logic              select_ram_c_dma, select_ram_d_dma;
    logic              w_a, w_b, cmd_swap, cmd_reject, interrupt;

    int n_total = 0;
    int n_pass  = 0;

    ram_chunk_swap_sequencer #(
        .ADDR_W    (ADDR_W),
        .CHUNK_MAX (CHUNK_MAX),
        .RD_LAT    (RD_LAT),
        .CMD_SWAP  (4'h5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .command           (command),
        .read_addr         (read_addr),
        .write_addr        (write_addr),
        .num_chunks        (num_chunks),
        .select_ram_c_or_d (select_ram_c_or_d),
        .select_ram_a_or_b (select_ram_a_or_b),
        .adbus_c           (adbus_c),
        .adbus_d           (adbus_d),
        .select_ram_c_dma  (select_ram_c_dma),
        .select_ram_d_dma  (select_ram_d_dma),
        .w_a               (w_a),
        .adbus_a           (adbus_a),
        .w_b               (w_b),
        .adbus_b           (adbus_b),
        .cmd_swap          (cmd_swap),
        .cmd_reject        (cmd_reject),
        .interrupt         (interrupt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [18:0] pk(int c, int d, int cd, int dd, int wa, int aa,
                                       int wb, int ab, int busy, int rej, int irq);
        return {ADDR_W'(c), ADDR_W'(d), 1'(cd), 1'(dd), 1'(wa), ADDR_W'(aa),
                1'(wb), ADDR_W'(ab), 1'(busy), 1'(rej), 1'(irq)};
    endfunction

    // Check the current cycle at the falling edge, then advance to just
    // after the next rising edge where the next cycle's inputs are driven.
    task automatic cyc(input string tag, input logic [18:0] exp_v);
        logic [18:0] obs;
        @(negedge clk);
        obs = {adbus_c, adbus_d, select_ram_c_dma, select_ram_d_dma, w_a, adbus_a,
               w_b, adbus_b, cmd_swap, cmd_reject, interrupt};
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int ra, input int wa, input int n, input int src, input int dst);
        command           = 4'h5;
        read_addr         = ADDR_W'(ra);
        write_addr        = ADDR_W'(wa);
        num_chunks        = CNT_W'(n);
        select_ram_c_or_d = 1'(src);
        select_ram_a_or_b = 1'(dst);
    endtask

    initial begin
        rst = 1'b1;
        command = 4'h0; read_addr = '0; write_addr = '0; num_chunks = '0;
        select_ram_c_or_d = 1'b0; select_ram_a_or_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", pk(0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b0;
        cyc("idle", pk(0,0,0,0,0,0,0,0,0,0,0));

        // 1: C->A, ra=5 wa=6 n=3
        setup(5, 6, 3, 1, 1);
        cyc("t1_c0", pk(0,0,0,0,0,0,0,0,0,0,0));
        command = 4'h0;
        cyc("t1_c1", pk(5,0,0,0,0,0,0,0,1,0,0));
        cyc("t1_c2", pk(4,0,0,0,0,0,0,0,1,0,0));
        cyc("t1_c3", pk(3,0,1,0,1,6,0,0,1,0,0));
        cyc("t1_c4", pk(3,0,1,0,1,5,0,0,1,0,0));
        cyc("t1_c5", pk(3,0,1,0,1,4,0,0,1,0,0));
        cyc("t1_c6", pk(3,0,0,0,0,4,0,0,1,0,1));
        cyc("t1_c7", pk(3,0,0,0,0,4,0,0,0,0,0));

        // 2: D->B, ra=1 wa=0 n=2, destination address wraps to 7
        setup(1, 0, 2, 0, 0);
        cyc("t2_c0", pk(3,0,0,0,0,4,0,0,0,0,0));
        command = 4'h0;
        cyc("t2_c1", pk(3,1,0,0,0,4,0,0,1,0,0));
        cyc("t2_c2", pk(3,0,0,0,0,4,0,0,1,0,0));
        cyc("t2_c3", pk(3,0,0,1,0,4,1,0,1,0,0));
        cyc("t2_c4", pk(3,0,0,1,0,4,1,7,1,0,0));
        cyc("t2_c5", pk(3,0,0,0,0,4,0,7,1,0,1));
        cyc("t2_c6", pk(3,0,0,0,0,4,0,7,0,0,0));

        // 3: n=0 completes immediately with no writes
        setup(2, 2, 0, 1, 1);
        cyc("t3_c0", pk(3,0,0,0,0,4,0,7,0,0,0));
        command = 4'h0;
        cyc("t3_c1", pk(3,0,0,0,0,4,0,7,1,0,1));
        cyc("t3_c2", pk(3,0,0,0,0,4,0,7,0,0,0));

        // 3b: CMD_SWAP held: rejected in DONE, restarts on the next IDLE cycle
        setup(2, 2, 0, 1, 1);
        cyc("hold_c0", pk(3,0,0,0,0,4,0,7,0,0,0));
        cyc("hold_c1", pk(3,0,0,0,0,4,0,7,1,1,1));
        cyc("hold_c2", pk(3,0,0,0,0,4,0,7,0,0,0));
        cyc("hold_c3", pk(3,0,0,0,0,4,0,7,1,1,1));
        command = 4'h0;
        cyc("hold_c4", pk(3,0,0,0,0,4,0,7,0,0,0));

        // 4: n=7 clamps to 4, C->B, ra=1 wa=2 (both walks wrap)
        setup(1, 2, 7, 1, 0);
        cyc("t4_c0", pk(3,0,0,0,0,4,0,7,0,0,0));
        command = 4'h0;
        cyc("t4_c1", pk(1,0,0,0,0,4,0,7,1,0,0));
        cyc("t4_c2", pk(0,0,0,0,0,4,0,7,1,0,0));
        cyc("t4_c3", pk(7,0,1,0,0,4,1,2,1,0,0));
        cyc("t4_c4", pk(6,0,1,0,0,4,1,1,1,0,0));
        cyc("t4_c5", pk(6,0,1,0,0,4,1,0,1,0,0));
        cyc("t4_c6", pk(6,0,1,0,0,4,1,7,1,0,0));
        cyc("t4_c7", pk(6,0,0,0,0,4,0,7,1,0,1));
        cyc("t4_c8", pk(6,0,0,0,0,4,0,7,0,0,0));

        // 5: reject mid-transfer; input changes mid-transfer have no effect
        setup(5, 6, 3, 1, 1);
        cyc("t5_c0", pk(6,0,0,0,0,4,0,7,0,0,0));
        command = 4'h3; read_addr = '0; write_addr = '0; num_chunks = 1;
        select_ram_c_or_d = 1'b0; select_ram_a_or_b = 1'b0;
        cyc("t5_c1", pk(5,0,0,0,0,4,0,7,1,0,0));
        command = 4'h5;
        cyc("t5_c2", pk(4,0,0,0,0,4,0,7,1,1,0));
        command = 4'h0;
        cyc("t5_c3", pk(3,0,1,0,1,6,0,7,1,0,0));
        cyc("t5_c4", pk(3,0,1,0,1,5,0,7,1,0,0));
        cyc("t5_c5", pk(3,0,1,0,1,4,0,7,1,0,0));
        cyc("t5_c6", pk(3,0,0,0,0,4,0,7,1,0,1));
        cyc("t5_c7", pk(3,0,0,0,0,4,0,7,0,0,0));

        // 6: reset at T3 aborts; a fresh D->B transfer then runs cleanly
        setup(5, 6, 3, 1, 1);
        cyc("t6_c0", pk(3,0,0,0,0,4,0,7,0,0,0));
        command = 4'h0;
        cyc("t6_c1", pk(5,0,0,0,0,4,0,7,1,0,0));
        cyc("t6_c2", pk(4,0,0,0,0,4,0,7,1,0,0));
        rst = 1'b1;
        cyc("t6_c3", pk(3,0,1,0,1,6,0,7,1,0,0));
        rst = 1'b0;
        cyc("t6_c4", pk(0,0,0,0,0,0,0,0,0,0,0));
        setup(2, 1, 1, 0, 0);
        cyc("t6_c5", pk(0,0,0,0,0,0,0,0,0,0,0));
        command = 4'h0;
        cyc("t6_c6", pk(0,2,0,0,0,0,0,0,1,0,0));
        cyc("t6_c7", pk(0,2,0,0,0,0,0,0,1,0,0));
        cyc("t6_c8", pk(0,2,0,1,0,0,1,1,1,0,0));
        cyc("t6_c9", pk(0,2,0,0,0,0,0,1,1,0,1));
        cyc("t6_c10", pk(0,2,0,0,0,0,0,1,0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_chunk_swap_sequencer.md
Name: ram_chunk_swap_sequencer

Overview:
Parametrised chunk-transfer sequencer for the ECC multiplier datapath. On a swap command it streams N consecutive operand chunks from result RAM C or D into operand RAM A or B, walking addresses downward. It drives the RAM address and write-enable pins and the DMA read-data steering selects. It reports completion with a one-cycle interrupt. It replaces the fixed 1-3 chunk swap block with a pipelined, depth-generic version that has a configurable read latency and a proper busy/reject handshake.

Parameters:
ADDR_W, 3, RAM address width in bits. Addresses wrap modulo 2^ADDR_W.
CHUNK_MAX, 4, maximum chunks per transfer (>=1). CNT_W = $clog2(CHUNK_MAX+1).
RD_LAT, 2, RAM C/D read latency in cycles (>=1). This is the distance from source address issue to destination write.
CMD_SWAP, 4'h5, command code that starts a transfer.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
command  in  4  command bus, sampled every cycle
read_addr  in  ADDR_W  top source chunk address
write_addr  in  ADDR_W  top destination chunk address
num_chunks  in  CNT_W  chunks to move
select_ram_c_or_d  in  1  source select: 1 = C, 0 = D
select_ram_a_or_b  in  1  destination select: 1 = A, 0 = B
adbus_c  out  ADDR_W  RAM C read address
adbus_d  out  ADDR_W  RAM D read address
select_ram_c_dma  out  1  steer RAM C data to the destination
select_ram_d_dma  out  1  steer RAM D data to the destination
w_a  out  1  RAM A write enable
adbus_a  out  ADDR_W  RAM A address
w_b  out  1  RAM B write enable
adbus_b  out  ADDR_W  RAM B address
cmd_swap  out  1  busy flag, high while a transfer is active
cmd_reject  out  1  one-cycle pulse when a command is ignored
interrupt  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs are 0, all address buses 0, counters and the pipeline are cleared. Reset mid-transfer aborts immediately: no further writes and no interrupt.
- IDLE: if command==CMD_SWAP in cycle T:
  - latch the addresses, selects and n = min(num_chunks, CHUNK_MAX);
  - cmd_swap=1 from T+1;
  - go to ISSUE, or to DONE if n==0.
- ISSUE, issue index k=0..n-1, one per cycle starting T+1:
  - the selected source bus gets latched_read_addr-k (mod 2^ADDR_W);
  - the unselected source bus holds its last value;
  - after issue k=n-1, go to DRAIN.
- Write path: a token (valid, k) enters a RD_LAT-deep delay line at each issue. When token k emerges, in cycle T+1+RD_LAT+k:
  - the selected destination gets w=1 and adbus=latched_write_addr-k;
  - the other destination w=0, its address held;
  - the source DMA select is 1 and the other DMA select 0.
  - When no token emerges, both w=0 and both DMA selects are 0.
- DRAIN: wait until the delay line is empty, then go to DONE.
- DONE: interrupt=1 for exactly one cycle (T+RD_LAT+n+1, or T+1 for n==0). cmd_swap falls in the next cycle. Go to IDLE.
- Commands:
  - CMD_SWAP while cmd_swap=1: ignored, cmd_reject=1 for that cycle, latched values untouched.
  - Non-CMD_SWAP codes are ignored silently.
  - CMD_SWAP held high across cycles after DONE starts a new transfer on the first IDLE cycle it is sampled.
- Inputs other than command are sampled only at the start cycle. Changing them mid-transfer has no effect.
- Address arithmetic is ADDR_W-bit unsigned subtraction; wrap below 0 is intended, e.g. 0-1 = 2^ADDR_W-1.
- Writes are strictly in order k=0..n-1. There is never more than one write per cycle and never a write to both A and B.

Decomposition:
- Shared package ecc_ram_pkg:
  - command codes (CMD_SWAP = 4'h5);
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - RAM select encodings (SRC_C=1, SRC_D=0, DST_A=1, DST_B=0).
- Sub-module ram_rd_lat_pipe: a RAM read-latency delay line carrying a valid bit and a CNT_W-bit index, depth RD_LAT, cleared by rst. It is reusable by other RAM sequencers.

Test Plan (ADDR_W=3, RD_LAT=2, CHUNK_MAX=4):
1. command=5 at T0, read_addr=5, write_addr=6, n=3, C->A -> adbus_c 5,4,3 at T1..T3; w_a=1 with adbus_a 6,5,4 at T3..T5; select_ram_c_dma=1 at T3..T5; interrupt only at T6; cmd_swap high T1..T6.
2. D->B, read_addr=1, write_addr=0, n=2 -> adbus_d 1,0; adbus_b 0,7 (wrap); w_a stays 0 throughout; select_ram_d_dma=1 on both write cycles.
3. n=0 -> no writes; interrupt at T1; cmd_swap high only in T1.
4. n=7 (>CHUNK_MAX) -> exactly 4 writes; interrupt at T0+RD_LAT+5.
5. command=5 again at T2 during transfer 1 -> cmd_reject pulse at T2; transfer 1 completes unchanged with exactly one interrupt.
6. rst asserted at T3 of transfer 1 -> from T4 all outputs 0, no interrupt; a new command=5 at T5 runs a full transfer correctly.
